// File: rtl/dft_result_serializer.sv
// dft_result_serializer: captures 4-bin frames from the DFT network into a
// two-entry ping-pong buffer and streams them one complex word per cycle.
module dft_result_serializer #(
  parameter int WORD_SZ = 16,
  parameter bit BIT_REV = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_valid,
  output logic               o_frame_ready,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_C,
  input  logic [WORD_SZ-1:0] i_D,
  output logic [WORD_SZ-1:0] o_data,
  output logic [1:0]         o_index,
  output logic               o_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_drop
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e               state_q, state_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         k_q, k_d;
  logic               drop_q, drop_d;
  logic [WORD_SZ-1:0] buf_q [2][4];
  logic [WORD_SZ-1:0] buf_d [2][4];

  logic               frame_ready;
  logic               valid_int;
  logic               accept;
  logic               rel;
  logic [1:0]         idx;

  // Output view of the frame at rd_ptr; everything is forced to zero when not valid
  always_comb begin
    frame_ready   = !i_rst && (state_q != FULL);
    valid_int     = !i_rst && (state_q != EMPTY);
    idx           = BIT_REV ? {k_q[0], k_q[1]} : k_q;
    accept        = i_frame_valid && frame_ready;
    rel           = valid_int && i_ready && (k_q == 2'd3);
    o_frame_ready = frame_ready;
    o_valid       = valid_int;
    o_index       = valid_int ? idx : '0;
    o_last        = valid_int && (k_q == 2'd3);
    o_data        = valid_int ? buf_q[rd_ptr_q][idx] : '0;
    o_drop        = drop_q;
  end

  // Next-state: occupancy, pointers, word counter, sticky overflow flag, capture
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    drop_d   = drop_q | (i_frame_valid & ~frame_ready & ~i_rst);
    buf_d    = buf_q;

    if (accept && !rel) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = FULL;
        default: state_d = state_q;
      endcase
    end else if (rel && !accept) begin
      case (state_q)
        FULL:    state_d = ONE;
        ONE:     state_d = EMPTY;
        default: state_d = state_q;
      endcase
    end

    if (accept) begin
      buf_d[wr_ptr_q][0] = i_A;
      buf_d[wr_ptr_q][1] = i_B;
      buf_d[wr_ptr_q][2] = i_C;
      buf_d[wr_ptr_q][3] = i_D;
      wr_ptr_d           = ~wr_ptr_q;
    end

    if (valid_int && i_ready) begin
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      k_q      <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      k_q      <= k_d;
      drop_q   <= drop_d;
    end
  end

  // Frame storage; contents are unobservable while empty, so no reset is needed
  always_ff @(posedge i_clk) begin
    for (int unsigned e = 0; e < 2; e++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        buf_q[e][b] <= buf_d[e][b];
      end
    end
  end

endmodule

// File: tb/tb_dft_result_serializer.sv
// Self-checking bench for dft_result_serializer: cycle table plus a bit-reversed sequence.
module tb_dft_result_serializer;

  logic        clk = 1'b0;
  logic        rst, fv, rdy;
  logic [15:0] a, b, c, d;
  logic        fr, v, last, drop;
  logic [15:0] data;
  logic [1:0]  idx;
  logic        fr_r, v_r, last_r, drop_r;
  logic [15:0] data_r;
  logic [1:0]  idx_r;

  int checks = 0;
  int failures = 0;
  int cur_row = -1;

  always #5 clk = ~clk;

  dft_result_serializer #(.WORD_SZ(16), .BIT_REV(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_valid(fv), .o_frame_ready(fr),
    .i_A(a), .i_B(b), .i_C(c), .i_D(d),
    .o_data(data), .o_index(idx), .o_last(last), .o_valid(v),
    .i_ready(rdy), .o_drop(drop)
  );

  dft_result_serializer #(.WORD_SZ(16), .BIT_REV(1'b1)) dut_rev (
    .i_clk(clk), .i_rst(rst), .i_frame_valid(fv), .o_frame_ready(fr_r),
    .i_A(a), .i_B(b), .i_C(c), .i_D(d),
    .o_data(data_r), .o_index(idx_r), .o_last(last_r), .o_valid(v_r),
    .i_ready(rdy), .o_drop(drop_r)
  );

  typedef struct {
    logic        rst;
    logic        fv;
    int          fsel;  // 0 none, 1 X, 2 Y, 3 P, 4 Q
    logic        rdy;
    logic        fr;
    logic        v;
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
    logic        drop;
  } vec_t;

  vec_t tbl[$];

  // Frame contents: X=0101..0104, Y=0201..0204, P=1111..4444, Q=5555..8888
  function automatic logic [15:0] fw(int fsel, int bin);
    case (fsel)
      1:       fw = 16'h0101 + 16'(bin);
      2:       fw = 16'h0201 + 16'(bin);
      3:       fw = 16'h1111 * 16'(bin + 1);
      4:       fw = 16'h1111 * 16'(bin + 5);
      default: fw = 16'h0000;
    endcase
  endfunction

  task automatic row(input logic r, input logic f, input int fs, input logic rd,
                     input logic efr, input logic ev, input logic [15:0] ed,
                     input logic [1:0] ei, input logic el, input logic edr);
    vec_t t;
    t.rst = r; t.fv = f; t.fsel = fs; t.rdy = rd;
    t.fr = efr; t.v = ev; t.data = ed; t.idx = ei; t.last = el; t.drop = edr;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input int fs, input logic rd);
    rst = r; fv = f; rdy = rd;
    a = fw(fs, 0); b = fw(fs, 1); c = fw(fs, 2); d = fw(fs, 3);
  endtask

  task automatic drive_words(input logic [15:0] wa, input logic [15:0] wb,
                             input logic [15:0] wc, input logic [15:0] wd);
    rst = 1'b0; fv = 1'b1; rdy = 1'b1;
    a = wa; b = wb; c = wc; d = wd;
  endtask

  logic [15:0] rev_data [4];
  logic [1:0]  rev_idx  [4];
  logic [15:0] nat_data [4];

  initial begin
    drive(1'b1, 1'b0, 0, 1'b1);
    repeat (2) @(posedge clk);

    //  rst fv fs rdy | fr v  data     idx   last drop
    row(1, 0, 0, 1,   0, 0, 16'h0000, 2'd0, 0, 0);  // in reset
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 0);  // first post-reset cycle
    row(0, 1, 1, 1,   1, 0, 16'h0000, 2'd0, 0, 0);  // accept X
    row(0, 0, 0, 1,   1, 1, 16'h0101, 2'd0, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h0102, 2'd1, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h0103, 2'd2, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h0104, 2'd3, 1, 0);
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 0);  // drained
    row(0, 1, 1, 1,   1, 0, 16'h0000, 2'd0, 0, 0);  // accept X
    row(0, 1, 2, 1,   1, 1, 16'h0101, 2'd0, 0, 0);  // accept Y -> FULL
    row(0, 0, 0, 1,   0, 1, 16'h0102, 2'd1, 0, 0);
    row(0, 0, 0, 1,   0, 1, 16'h0103, 2'd2, 0, 0);
    row(0, 0, 0, 1,   0, 1, 16'h0104, 2'd3, 1, 0);  // release -> ONE
    row(0, 0, 0, 1,   1, 1, 16'h0201, 2'd0, 0, 0);  // no bubble
    row(0, 0, 0, 1,   1, 1, 16'h0202, 2'd1, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h0203, 2'd2, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h0204, 2'd3, 1, 0);
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 0);
    row(0, 1, 3, 0,   1, 0, 16'h0000, 2'd0, 0, 0);  // stall begins, accept P
    row(0, 1, 4, 0,   1, 1, 16'h1111, 2'd0, 0, 0);  // accept Q
    row(0, 1, 4, 0,   0, 1, 16'h1111, 2'd0, 0, 0);  // offer while full
    for (int i = 0; i < 7; i++)
      row(0, 1, 4, 0, 0, 1, 16'h1111, 2'd0, 0, 1);
    row(0, 0, 0, 1,   0, 1, 16'h1111, 2'd0, 0, 1);
    row(0, 0, 0, 1,   0, 1, 16'h2222, 2'd1, 0, 1);
    row(0, 0, 0, 1,   0, 1, 16'h3333, 2'd2, 0, 1);
    row(0, 0, 0, 1,   0, 1, 16'h4444, 2'd3, 1, 1);
    row(0, 0, 0, 1,   1, 1, 16'h5555, 2'd0, 0, 1);  // ready rises after release
    row(0, 0, 0, 1,   1, 1, 16'h6666, 2'd1, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h7777, 2'd2, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h8888, 2'd3, 1, 1);
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 1);
    row(0, 1, 1, 1,   1, 0, 16'h0000, 2'd0, 0, 1);  // accept X
    row(0, 0, 0, 1,   1, 1, 16'h0101, 2'd0, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h0102, 2'd1, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h0103, 2'd2, 0, 1);
    row(0, 1, 2, 1,   1, 1, 16'h0104, 2'd3, 1, 1);  // accept Y + release in ONE
    row(0, 0, 0, 1,   1, 1, 16'h0201, 2'd0, 0, 1);
    row(0, 0, 0, 0,   1, 1, 16'h0202, 2'd1, 0, 1);  // hold under stall
    row(0, 0, 0, 0,   1, 1, 16'h0202, 2'd1, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h0202, 2'd1, 0, 1);
    row(0, 0, 0, 1,   1, 1, 16'h0203, 2'd2, 0, 1);
    row(1, 0, 0, 1,   0, 0, 16'h0000, 2'd0, 0, 1);  // reset mid-frame
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 0);
    row(0, 1, 3, 1,   1, 0, 16'h0000, 2'd0, 0, 0);  // fresh frame P
    row(0, 0, 0, 1,   1, 1, 16'h1111, 2'd0, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h2222, 2'd1, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h3333, 2'd2, 0, 0);
    row(0, 0, 0, 1,   1, 1, 16'h4444, 2'd3, 1, 0);
    row(0, 0, 0, 1,   1, 0, 16'h0000, 2'd0, 0, 0);

    foreach (tbl[i]) begin
      cur_row = i;
      #1;
      drive(tbl[i].rst, tbl[i].fv, tbl[i].fsel, tbl[i].rdy);
      @(negedge clk);
      chk("frame_ready", 32'(fr),   32'(tbl[i].fr));
      chk("valid",       32'(v),    32'(tbl[i].v));
      chk("data",        32'(data), 32'(tbl[i].data));
      chk("index",       32'(idx),  32'(tbl[i].idx));
      chk("last",        32'(last), 32'(tbl[i].last));
      chk("drop",        32'(drop), 32'(tbl[i].drop));
      @(posedge clk);
    end

    // Bit-reversed ordering: A..D = 0400, 0000, 00FF, 0001
    rev_data = '{16'h0400, 16'h00FF, 16'h0000, 16'h0001};
    rev_idx  = '{2'd0, 2'd2, 2'd1, 2'd3};
    nat_data = '{16'h0400, 16'h0000, 16'h00FF, 16'h0001};
    cur_row = 1000;
    #1;
    drive_words(16'h0400, 16'h0000, 16'h00FF, 16'h0001);
    @(posedge clk);
    #1;
    fv = 1'b0;
    for (int w = 0; w < 4; w++) begin
      cur_row = 1000 + w;
      @(negedge clk);
      chk("rev_valid", 32'(v_r),    32'd1);
      chk("rev_data",  32'(data_r), 32'(rev_data[w]));
      chk("rev_index", 32'(idx_r),  32'(rev_idx[w]));
      chk("rev_last",  32'(last_r), (w == 3) ? 32'd1 : 32'd0);
      chk("nat_data",  32'(data),   32'(nat_data[w]));
      @(posedge clk);
    end
    cur_row = 1004;
    @(negedge clk);
    chk("rev_valid_after", 32'(v_r), 32'd0);
    chk("rev_drop",        32'(drop_r), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dft_result_serializer.md
Name: dft_result_serializer

Overview:
- Reader side of the DFT_Network 4-point parallel output bus.
- Captures one frame (o_net_A..o_net_D, packed {real, imag}) per handshake into a two-entry ping-pong buffer.
- Streams the captured frame out one complex word per cycle on a valid/ready interface toward downstream memory or the host link.
- Decouples the combinational DFT network from a back-pressured consumer without dropping frames, as long as the producer honours o_frame_ready.

Parameters:
- WORD_SZ, 16: complex word width; upper WORD_SZ/2 bits = real, lower WORD_SZ/2 = imag (two's complement); must be even.
- BIT_REV, 0: output order. 0 = natural A,B,C,D. 1 = bit-reversed A,C,B,D.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_frame_valid  in  1  producer presents a complete frame on i_A..i_D
- o_frame_ready  out  1  serializer can capture a frame this cycle
- i_A  in  WORD_SZ  network output bin 0
- i_B  in  WORD_SZ  network output bin 1
- i_C  in  WORD_SZ  network output bin 2
- i_D  in  WORD_SZ  network output bin 3
- o_data  out  WORD_SZ  current output word
- o_index  out  2  bin number of o_data (0=A … 3=D)
- o_last  out  1  o_data is the final word of its frame
- o_valid  out  1  o_data/o_index/o_last are valid
- i_ready  in  1  consumer accepts the word this cycle
- o_drop  out  1  sticky: a frame was offered while o_frame_ready=0

Behaviour:
- Reset (synchronous, i_rst high at a rising edge):
  - Occupancy goes to EMPTY; write and read pointers go to 0; word counter goes to 0; o_drop clears.
  - Output values while and after reset: o_valid=0, o_last=0, o_index=0, o_data=0.
  - o_frame_ready=0 while i_rst is high, and 1 the first cycle after.
  - Reset mid-stream discards both buffers with no further output.
- Occupancy FSM, states EMPTY/ONE/FULL; count = number of frames held:
  - accept = i_frame_valid & o_frame_ready
  - release = o_valid & i_ready & o_last
  - accept & !release: count+1. release & !accept: count-1. Both or neither: count unchanged.
  - o_frame_ready = !i_rst & (count != FULL). It depends on registered state only; there is no combinational path from i_ready.
- Capture:
  - On accept, all four inputs are registered into buffer[wr_ptr], then wr_ptr toggles.
  - Inputs are sampled only on the accept edge.
- Output:
  - o_valid = (count != EMPTY).
  - Word counter k counts 0..3 within the frame at rd_ptr.
  - o_index = k when BIT_REV=0; o_index = {k[0],k[1]} when BIT_REV=1.
  - o_data = buffer[rd_ptr][o_index]; o_last = (k==3).
  - On o_valid & i_ready, k increments. When k==3 the transfer releases the frame: k wraps to 0 and rd_ptr toggles.
  - While o_valid & !i_ready, o_data/o_index/o_last hold stable.
- Latency:
  - Frame accepted at edge N gives o_valid=1 with word 0 in the cycle after edge N, if the buffer was empty.
  - Sustained throughput is 4 words per frame with no bubbles between frames.
- Simultaneous events:
  - In state ONE with accept and release on the same edge, the next cycle presents word 0 of the new frame with o_valid held high.
  - In state FULL, accept cannot occur. A release drops the state to ONE and o_frame_ready rises on the next cycle.
- Overflow: i_frame_valid & !o_frame_ready & !i_rst sets o_drop; the offered frame is ignored. o_drop stays set until reset.
- Arithmetic: words pass through unmodified; no sign handling or width change.

Test Plan:
- Reset then idle -> o_valid=0, o_data=0, o_drop=0, o_frame_ready=1 from the first post-reset cycle.
- One frame, all inputs 16'h0100 (1+0j), i_ready=1 -> four consecutive words 16'h0100 with o_index 0,1,2,3; o_last only on the 4th; o_valid low afterwards.
- BIT_REV=1, A..D = 16'h0400, 16'h0000, 16'h00FF, 16'h0001 -> output sequence 16'h0400, 16'h00FF, 16'h0000, 16'h0001 with o_index 0,2,1,3.
- i_ready=0 for 10 cycles while i_frame_valid stays high -> two frames accepted; o_frame_ready=0 from the second accept; o_drop=1 on the next offer; o_data holds word 0 of frame 1 throughout.
- Back-to-back frames 16'h0100.. then 16'h0200.., i_ready=1 -> 8 contiguous valid words with no bubble; o_last on words 4 and 8.
- Assert i_rst after word 2 of a frame -> next cycle o_valid=0, o_drop=0; a following fresh frame streams from o_index 0.
